function_sweep_checker: RTL and testbench

FUNCTION_SWEEP_CHECKER -- requirements
Module: function_sweep_checker

---
 rtl/function_sweep_pkg.sv | 18 +
 rtl/sweep_hold_timer.sv | 39 +++
 rtl/function_sweep_checker.sv | 100 ++++++++++
 tb/tb_function_sweep_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/function_sweep_pkg.sv
// Shared types and constants for the function sweep checker and its hold timer.
package function_sweep_pkg;

    localparam int VEC_COUNT = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Maps a vector index to the stimulus bits {S[1], S[0], Z}; S[0] carries the index MSB.
    function automatic logic [2:0] stim_of(input logic [IDX_W-1:0] idx);
        return {idx[1], idx[2], idx[0]};
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Counts the cycles a vector has been held; last marks the cycle on which F is sampled.
module sweep_hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int              CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last = en && (count_q == LAST_CNT);

    always_comb begin
        // NOTE: assign the default before any branch so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/function_sweep_checker.sv
// Drives all eight S/Z vectors into a unit under test, compares F against EXPECTED,
// and reports error count, first failing index and pass.
module function_sweep_checker
    import function_sweep_pkg::*;
#(
    parameter int                   HOLD_CYCLES = 10,
    parameter logic [VEC_COUNT-1:0] EXPECTED    = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] S,
    output logic       Z,
    input  logic       F,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       err_q, err_d;
    logic [IDX_W-1:0] ff_q, ff_d;
    logic             done_q, done_d;
    logic             sample;
    logic             accept;

    assign busy       = (state_q == APPLY);
    assign accept     = start && !busy;
    assign {S, Z}     = busy ? stim_of(idx_q) : 3'b000;
    assign done       = done_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign pass       = done_q && (err_q == 4'd0);

    sweep_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .en   (busy),
        .last (sample)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ff_d    = ff_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    err_d   = 4'd0;
                    ff_d    = '0;
                    done_d  = 1'b0;
                end
            end
            APPLY: begin
                if (sample) begin
                    if (F != EXPECTED[idx_q]) begin
                        err_d = err_q + 4'd1;
                        if (err_q == 4'd0) ff_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 4'd0;
            ff_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_function_sweep_checker.sv
// Scoreboard bench: three checker instances with different HOLD_CYCLES/EXPECTED share one clock.
module tb_function_sweep_checker;

    typedef struct {
        logic [3:0] err;
        logic [2:0] ff;
        logic       pass;
    } result_t;

    logic       clk = 1'b0;
    logic       rst_n  [3];
    logic       start  [3];
    logic       f      [3];
    logic [1:0] s_w    [3];
    logic       z_w    [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [3:0] err_w  [3];
    logic [2:0] ff_w   [3];

    logic [2:0] sz_q[$];
    result_t    res_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    function_sweep_checker #(.HOLD_CYCLES(10), .EXPECTED(8'h00)) u_zero (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .S(s_w[0]), .Z(z_w[0]), .F(f[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]), .first_fail(ff_w[0]));

    function_sweep_checker #(.HOLD_CYCLES(10), .EXPECTED(8'hA5)) u_a5 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .S(s_w[1]), .Z(z_w[1]), .F(f[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]), .first_fail(ff_w[1]));

    function_sweep_checker #(.HOLD_CYCLES(2), .EXPECTED(8'h3C)) u_fast (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .S(s_w[2]), .Z(z_w[2]), .F(f[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]), .first_fail(ff_w[2]));

    function automatic int hold_of(input int u);
        return (u == 2) ? 2 : 10;
    endfunction

    function automatic logic [7:0] pattern_of(input int u);
        case (u)
            0:       return 8'h00;
            1:       return 8'hA5;
            default: return 8'h3C;
        endcase
    endfunction

    // F modes: 0 tied low, 1 tied high, 2 correct, 3 wrong only in first hold cycle,
    // 4 correct only in first hold cycle.
    function automatic logic f_value(input int mode, input logic b, input int phase);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return b;
            3:       return (phase == 0) ? ~b : b;
            default: return (phase == 0) ? b : ~b;
        endcase
    endfunction

    // Runs one sweep on unit u; stop_at >= 0 abandons it at that cycle, leaving the DUT mid-sweep.
    task automatic run_sweep(input int u, input int mode, input bit hold_start, input int stop_at);
        int         h;
        logic [7:0] pat;
        result_t    r;
        logic [2:0] exp_sz;
        logic [2:0] got_sz;
        h   = hold_of(u);
        pat = pattern_of(u);
        r.err = 4'd0;
        r.ff  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (f_value(mode, pat[k], h - 1) != pat[k]) begin
                if (r.err == 4'd0) r.ff = 3'(k);
                r.err++;
            end
        end
        r.pass = (r.err == 4'd0);
        for (int c = 0; c < 8 * h; c++) sz_q.push_back(3'(c / h));
        res_q.push_back(r);

        @(negedge clk);
        start[u] = 1'b1;
        for (int c = 0; c < 8 * h; c++) begin
            @(negedge clk);
            if (!hold_start) start[u] = 1'b0;
            if (c == stop_at) begin
                sz_q.delete();
                res_q.delete();
                return;
            end
            exp_sz = sz_q.pop_front();
            got_sz = {s_w[u][0], s_w[u][1], z_w[u]};
            n_checks++;
            if (got_sz !== exp_sz || busy_w[u] !== 1'b1 || done_w[u] !== 1'b0)
                $display("FAIL sweep_vec u%0d c%0d: got idx=%0d busy=%b done=%b, expected idx=%0d busy=1 done=0",
                         u, c, got_sz, busy_w[u], done_w[u], exp_sz);
            else n_pass++;
            f[u] = f_value(mode, pat[c / h], c % h);
        end

        @(negedge clk);
        f[u] = 1'b0;
        r = res_q.pop_front();
        n_checks++;
        if (done_w[u] !== 1'b1 || busy_w[u] !== 1'b0 || s_w[u] !== 2'b00 || z_w[u] !== 1'b0)
            $display("FAIL sweep_end u%0d: got done=%b busy=%b S=%b Z=%b, expected done=1 busy=0 S=00 Z=0",
                     u, done_w[u], busy_w[u], s_w[u], z_w[u]);
        else n_pass++;
        n_checks++;
        if (err_w[u] !== r.err || ff_w[u] !== r.ff || pass_w[u] !== r.pass)
            $display("FAIL sweep_result u%0d: got err=%0d ff=%0d pass=%b, expected err=%0d ff=%0d pass=%b",
                     u, err_w[u], ff_w[u], pass_w[u], r.err, r.ff, r.pass);
        else n_pass++;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            rst_n[u] = 1'b0;
            start[u] = 1'b0;
            f[u]     = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            n_checks++;
            if (s_w[u] !== 2'b00 || z_w[u] !== 1'b0 || busy_w[u] !== 1'b0 || done_w[u] !== 1'b0 ||
                pass_w[u] !== 1'b0 || err_w[u] !== 4'd0 || ff_w[u] !== 3'd0)
                $display("FAIL reset_state u%0d: got S=%b Z=%b busy=%b done=%b pass=%b err=%0d ff=%0d, expected all 0",
                         u, s_w[u], z_w[u], busy_w[u], done_w[u], pass_w[u], err_w[u], ff_w[u]);
            else n_pass++;
        end
    endtask

    task automatic test_sweep_zero();
        run_sweep(0, 0, 1'b0, -1);
    endtask

    task automatic test_model_a5();
        run_sweep(1, 2, 1'b0, -1);
    endtask

    task automatic test_tied_high_a5();
        run_sweep(1, 1, 1'b0, -1);
    endtask

    task automatic test_reset_mid_sweep();
        run_sweep(1, 1, 1'b0, 35);
        rst_n[1] = 1'b0;
        #1;
        n_checks++;
        if (s_w[1] !== 2'b00 || z_w[1] !== 1'b0 || busy_w[1] !== 1'b0 || done_w[1] !== 1'b0 ||
            pass_w[1] !== 1'b0 || err_w[1] !== 4'd0 || ff_w[1] !== 3'd0)
            $display("FAIL abort_reset: got S=%b Z=%b busy=%b done=%b pass=%b err=%0d ff=%0d, expected all 0",
                     s_w[1], z_w[1], busy_w[1], done_w[1], pass_w[1], err_w[1], ff_w[1]);
        else n_pass++;
        @(negedge clk);
        rst_n[1] = 1'b1;
        run_sweep(1, 1, 1'b0, -1);
    endtask

    task automatic test_fast_hold();
        run_sweep(2, 3, 1'b0, -1);
        run_sweep(2, 4, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_sweep(0, 0, 1'b1, -1);
        @(negedge clk);
        n_checks++;
        if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b1 || s_w[0] !== 2'b00 || z_w[0] !== 1'b0)
            $display("FAIL restart_held: got done=%b busy=%b S=%b Z=%b, expected done=0 busy=1 S=00 Z=0",
                     done_w[0], busy_w[0], s_w[0], z_w[0]);
        else n_pass++;
        start[0] = 1'b0;
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sweep_zero();
        test_model_a5();
        test_tied_high_a5();
        test_reset_mid_sweep();
        test_fast_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
